// File: rtl/mem2serial_fmt_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem2serial_fmt_pkg
// Brief   : Shared definitions for the FIFO-to-UART drain: state encodings
//           and trailer byte constants.
// Revision: 1.0 - initial release
// ============================================================================
package mem2serial_fmt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_SEND       = 3'd2,
        ST_WAIT       = 3'd3,
        ST_TRAIL      = 3'd4,
        ST_TRAIL_WAIT = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

    localparam logic [7:0] TRAILER_LF = 8'h0A;
    localparam logic [7:0] TRAILER_CR = 8'h0D;

endpackage
`default_nettype wire

// File: rtl/mem2serial_fmt_nibble2ascii.sv
`default_nettype none
// ============================================================================
// Module  : mem2serial_fmt_nibble2ascii
// Brief   : Combinational 4-bit value to uppercase ASCII hex character.
// Ports   : nibble - 4-bit value in
//           ascii  - 8-bit character out ("0".."9", "A".."F")
// Revision: 1.0 - initial release
// ============================================================================
module mem2serial_fmt_nibble2ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h30 + {4'd0, nibble};
        if (nibble > 4'd9) begin
            // 'A' is 0x41, so 10 maps to 0x41 via an offset of 0x37.
            ascii = 8'h37 + {4'd0, nibble};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem2serial_fmt.sv
`default_nettype none
// ============================================================================
// Module  : mem2serial_fmt
// Brief   : Drains capture words from a FIFO and streams them to a byte UART,
//           either as raw binary or uppercase ASCII hex (MSB first), with an
//           optional LF/CR trailer after each word. All state changes on the
//           falling clock edge.
// Ports   : clock             - system clock (falling edge active)
//           reset             - asynchronous active-low reset
//           read_empty        - FIFO empty flag
//           read_data         - FIFO output word (DATA_W bits)
//           read_clock_enable - FIFO pop strobe
//           hex_mode          - 1 = ASCII hex, 0 = binary (sampled per word)
//           uart_ready        - UART can accept a byte
//           uart_data         - byte to transmit
//           uart_clock_enable - UART write strobe
//           busy              - word in flight
//           words_sent        - count of completed words (wraps)
// Revision: 1.0 - initial release
// ============================================================================
module mem2serial_fmt
    import mem2serial_fmt_pkg::*;
#(
    parameter int DATA_W     = 48,
    parameter bit TRAILER_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read_empty,
    input  logic [DATA_W-1:0] read_data,
    output logic              read_clock_enable,
    input  logic              hex_mode,
    input  logic              uart_ready,
    output logic [7:0]        uart_data,
    output logic              uart_clock_enable,
    output logic              busy,
    output logic [15:0]       words_sent
);

    localparam int N_BIN = DATA_W / 8;
    localparam int N_HEX = DATA_W / 4;
    localparam int IDX_W = $clog2(N_HEX);
    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(N_BIN - 1);
    localparam logic [IDX_W-1:0] LAST_HEX = IDX_W'(N_HEX - 1);

    state_t             r_state;
    logic [DATA_W-1:0]  r_word;
    logic               r_hex;
    logic [IDX_W-1:0]   r_idx;
    logic               r_trail_cr;
    logic               r_rce;
    logic               r_uce;
    logic [7:0]         r_udata;
    logic               r_busy;
    logic [15:0]        r_words_sent;

    logic [IDX_W+2:0]   w_shamt;
    logic [7:0]         w_byte;
    logic [7:0]         w_ascii;
    logic [7:0]         w_char;

    // Shift the current byte or nibble down to bit 0; in hex mode only the
    // low nibble of w_byte is meaningful.
    assign w_shamt = r_hex ? {1'b0, r_idx, 2'b00} : {r_idx, 3'b000};
    assign w_byte  = 8'(r_word >> w_shamt);
    assign w_char  = r_hex ? w_ascii : w_byte;

    mem2serial_fmt_nibble2ascii u_nibble2ascii (
        .nibble (w_byte[3:0]),
        .ascii  (w_ascii)
    );

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_word       <= '0;
            r_hex        <= 1'b0;
            r_idx        <= '0;
            r_trail_cr   <= 1'b0;
            r_rce        <= 1'b0;
            r_uce        <= 1'b0;
            r_udata      <= 8'h00;
            r_busy       <= 1'b0;
            r_words_sent <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!read_empty) begin
                        r_rce   <= 1'b1;
                        r_state <= ST_FETCH;
                    end else begin
                        r_rce   <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    // Word is committed here regardless of read_empty.
                    r_rce      <= 1'b0;
                    r_word     <= read_data;
                    r_hex      <= hex_mode;
                    r_busy     <= 1'b1;
                    r_idx      <= hex_mode ? LAST_HEX : LAST_BIN;
                    r_trail_cr <= 1'b0;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (uart_ready) begin
                        r_uce   <= 1'b1;
                        r_udata <= w_char;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Strobe stays high until the UART drops ready.
                    if (!uart_ready) begin
                        r_uce <= 1'b0;
                        if (r_idx == '0) begin
                            r_state <= TRAILER_EN ? ST_TRAIL : ST_DONE;
                        end else begin
                            r_idx   <= r_idx - IDX_W'(1);
                            r_state <= ST_SEND;
                        end
                    end
                end
                ST_TRAIL: begin
                    if (uart_ready) begin
                        r_uce   <= 1'b1;
                        r_udata <= r_trail_cr ? TRAILER_CR : TRAILER_LF;
                        r_state <= ST_TRAIL_WAIT;
                    end
                end
                ST_TRAIL_WAIT: begin
                    if (!uart_ready) begin
                        r_uce <= 1'b0;
                        if (r_trail_cr) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_trail_cr <= 1'b1;
                            r_state    <= ST_TRAIL;
                        end
                    end
                end
                ST_DONE: begin
                    r_words_sent <= r_words_sent + 16'd1;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign read_clock_enable = r_rce;
    assign uart_clock_enable = r_uce;
    assign uart_data         = r_udata;
    assign busy              = r_busy;
    assign words_sent        = r_words_sent;

endmodule
`default_nettype wire

// File: tb/tb_mem2serial_fmt.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem2serial_fmt
// Brief   : Scoreboard bench for mem2serial_fmt (DATA_W=48, TRAILER_EN=1).
//           Stimulus pushes expected UART bytes and per-word busy width /
//           word count into queues; FIFO, UART and busy monitors compare.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem2serial_fmt;

    localparam int DATA_W = 48;
    localparam int NB     = DATA_W / 8;
    localparam int NH     = DATA_W / 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              read_empty;
    logic [DATA_W-1:0] read_data;
    logic              read_clock_enable;
    logic              hex_mode = 1'b0;
    logic              uart_ready = 1'b1;
    logic [7:0]        uart_data;
    logic              uart_clock_enable;
    logic              busy;
    logic [15:0]       words_sent;

    mem2serial_fmt #(
        .DATA_W     (DATA_W),
        .TRAILER_EN (1'b1)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .read_empty        (read_empty),
        .read_data         (read_data),
        .read_clock_enable (read_clock_enable),
        .hex_mode          (hex_mode),
        .uart_ready        (uart_ready),
        .uart_data         (uart_data),
        .uart_clock_enable (uart_clock_enable),
        .busy              (busy),
        .words_sent        (words_sent)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // ---------------- FIFO model (first-word-fall-through) ----------------
    logic [DATA_W-1:0] fifo_mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pops   = 0;

    assign read_empty = (wr_ptr == rd_ptr);
    assign read_data  = fifo_mem[rd_ptr[5:0]];

    always @(posedge clock) begin
        if (read_clock_enable) begin
            pops++;
            check("pop_while_busy", {63'd0, busy}, 64'd0);
            @(negedge clock);
            #1;
            rd_ptr++;
        end
    end

    // ---------------- scoreboard queues ----------------
    typedef struct {
        int          width;
        logic [15:0] ws;
    } wexp_t;

    logic [7:0] exp_bytes [$];
    wexp_t      exp_words [$];
    int         ack_lat = 3;
    int         strobes = 0;

    // ---------------- UART model + byte monitor ----------------
    int u_st  = 0;
    int u_cnt = 0;

    always @(posedge clock) begin
        case (u_st)
            0: begin
                if (uart_clock_enable) begin
                    strobes++;
                    if (exp_bytes.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL uart_byte: got 0x%02h, expected no byte", uart_data);
                    end else begin
                        check("uart_byte", {56'd0, uart_data}, {56'd0, exp_bytes.pop_front()});
                    end
                    u_cnt = ack_lat;
                    u_st  = 1;
                end
            end
            1: begin
                u_cnt--;
                if (u_cnt <= 0) begin
                    if (reset) check("uce_hold", {63'd0, uart_clock_enable}, 64'd1);
                    uart_ready = 1'b0;
                    u_st       = 2;
                end
            end
            default: begin
                if (!uart_clock_enable) begin
                    uart_ready = 1'b1;
                    u_st       = 0;
                end
            end
        endcase
    end

    // ---------------- busy pulse / word count monitor ----------------
    int bcnt = 0;

    always @(posedge clock) begin
        if (!reset) begin
            bcnt = 0;
        end else if (busy) begin
            bcnt++;
        end else if (bcnt != 0) begin
            if (exp_words.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL word_end: got busy pulse of %0d, expected none", bcnt);
            end else begin
                wexp_t e;
                e = exp_words.pop_front();
                check("busy_width", 64'(bcnt), 64'(e.width));
                check("words_sent", {48'd0, words_sent}, {48'd0, e.ws});
            end
            bcnt = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    string       hexdig   = "0123456789ABCDEF";
    logic [15:0] ws_model = 16'd0;

    task automatic push_fifo(input logic [DATA_W-1:0] w);
        fifo_mem[wr_ptr[5:0]] = w;
        wr_ptr++;
    endtask

    task automatic expect_word(input logic [DATA_W-1:0] w, input bit hex, input int lat);
        int nb;
        if (hex) begin
            for (int i = NH - 1; i >= 0; i--) exp_bytes.push_back(hexdig[int'(w[4*i +: 4])]);
            nb = NH + 2;
        end else begin
            for (int i = NB - 1; i >= 0; i--) exp_bytes.push_back(w[8*i +: 8]);
            nb = NB + 2;
        end
        exp_bytes.push_back(8'h0A);
        exp_bytes.push_back(8'h0D);
        ws_model = ws_model + 16'd1;
        exp_words.push_back('{width: nb * (lat + 2) + 1, ws: ws_model});
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_bytes.size() != 0 || exp_words.size() != 0 || wr_ptr != rd_ptr || busy) && n < 3000) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, got %0d bytes %0d words pending, expected 0", name,
                     exp_bytes.size(), exp_words.size());
            exp_bytes.delete();
            exp_words.delete();
        end
        repeat (4) @(negedge clock);
        #1;
    endtask

    task automatic wait_strobes(input int target, input string name);
        int n = 0;
        while (strobes < target && n < 500) begin
            @(posedge clock);
            n++;
        end
        if (strobes < target) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0d strobes, expected %0d", name, strobes, target);
        end
    endtask

    // Hand-computed byte streams for word 0x0123456789AB.
    logic [7:0] a_bin [8]  = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'h0A, 8'h0D};
    logic [7:0] a_hex [14] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                               8'h37, 8'h38, 8'h39, 8'h41, 8'h42, 8'h0A, 8'h0D};
    logic [7:0] e_bin [2]  = '{8'h11, 8'h22};

    localparam logic [DATA_W-1:0] W_A = 48'h0123456789AB;

    // ---------------- main sequence ----------------
    initial begin
        int s0;
        int p0;

        repeat (3) @(negedge clock);
        #1;
        check("rst_rce",   {63'd0, read_clock_enable}, 64'd0);
        check("rst_uce",   {63'd0, uart_clock_enable}, 64'd0);
        check("rst_data",  {56'd0, uart_data},         64'd0);
        check("rst_busy",  {63'd0, busy},              64'd0);
        check("rst_words", {48'd0, words_sent},        64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;

        // Binary word, ack latency 3: 8 bytes, busy = 8*5+1.
        foreach (a_bin[i]) exp_bytes.push_back(a_bin[i]);
        exp_words.push_back('{width: 41, ws: 16'd1});
        ws_model = 16'd1;
        push_fifo(W_A);
        wait_drain("bin_word");

        // Hex word: 14 strobes, busy = 14*5+1.
        hex_mode = 1'b1;
        s0 = strobes;
        foreach (a_hex[i]) exp_bytes.push_back(a_hex[i]);
        exp_words.push_back('{width: 71, ws: 16'd2});
        ws_model = 16'd2;
        push_fifo(W_A);
        wait_drain("hex_word");
        check("hex_strobes", 64'(strobes - s0), 64'd14);

        // Three words queued back to back.
        hex_mode = 1'b0;
        p0 = pops;
        expect_word(48'h000000000000, 1'b0, 3);
        expect_word(48'hFFFFFFFFFFFF, 1'b0, 3);
        expect_word(48'h800000000001, 1'b0, 3);
        push_fifo(48'h000000000000);
        push_fifo(48'hFFFFFFFFFFFF);
        push_fifo(48'h800000000001);
        wait_drain("b2b");
        check("b2b_pops", 64'(pops - p0), 64'd3);

        // hex_mode toggled during the 3rd byte of a hex word.
        hex_mode = 1'b1;
        s0 = strobes;
        expect_word(48'hFEDCBA987654, 1'b1, 3);
        expect_word(48'h0F1E2D3C4B5A, 1'b0, 3);
        push_fifo(48'hFEDCBA987654);
        push_fifo(48'h0F1E2D3C4B5A);
        wait_strobes(s0 + 3, "toggle_wait");
        @(negedge clock);
        #1;
        hex_mode = 1'b0;
        wait_drain("hex_toggle");

        // Slow UART: ready stays high for 12 cycles after each strobe.
        ack_lat = 12;
        expect_word(48'hA5A55A5AC3C3, 1'b0, 12);
        push_fifo(48'hA5A55A5AC3C3);
        wait_drain("slow_ack");
        ack_lat = 3;

        // Reset after the 2nd byte of a word.
        s0 = strobes;
        foreach (e_bin[i]) exp_bytes.push_back(e_bin[i]);
        push_fifo(48'h112233445566);
        wait_strobes(s0 + 2, "reset_wait");
        @(negedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("mid_rst_rce",   {63'd0, read_clock_enable}, 64'd0);
        check("mid_rst_uce",   {63'd0, uart_clock_enable}, 64'd0);
        check("mid_rst_data",  {56'd0, uart_data},         64'd0);
        check("mid_rst_busy",  {63'd0, busy},              64'd0);
        check("mid_rst_words", {48'd0, words_sent},        64'd0);
        repeat (10) @(negedge clock);
        #1;
        reset    = 1'b1;
        ws_model = 16'd0;
        expect_word(48'h66778899AABB, 1'b0, 3);
        push_fifo(48'h66778899AABB);
        wait_drain("after_reset");

        // words_sent wrap from 0xFFFF.
        force dut.r_words_sent = 16'hFFFF;
        @(negedge clock);
        #1;
        release dut.r_words_sent;
        @(negedge clock);
        #1;
        check("preset_words", {48'd0, words_sent}, 64'hFFFF);
        ws_model = 16'hFFFF;
        expect_word(W_A, 1'b0, 3);
        push_fifo(W_A);
        wait_drain("wrap");

        check("leftover_bytes", 64'(exp_bytes.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
